// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes common with the ALU control decoder,
// and the execute-unit FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier core; one partial product per step.
// Sequencing (start/step/clear) is owned by the enclosing FSM.
module mul_shift_add
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             last_o,
  output logic [WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_next;

  // Accumulator value after the current step; on the last step this is the product.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = acc_next;
  assign last_o    = step_i && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
    end else if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, multi-cycle multiply,
// valid/ready issue handshake and a one-cycle done pulse per result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             done_o
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             done_q,   done_d;
  logic             mul_start, mul_step, mul_last;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;

  function automatic logic [WIDTH-1:0] slt_fn(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    return {{(WIDTH-1){1'b0}}, (sa < sb)};
  endfunction

  // Single-cycle datapath; unknown codes (and MUL, which never uses it) give 0.
  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      ALU_AND: alu_res = src1_i & src2_i;
      ALU_OR:  alu_res = src1_i | src2_i;
      ALU_ADD: alu_res = src1_i + src2_i;
      ALU_SUB: alu_res = src1_i - src2_i;
      ALU_SLT: alu_res = slt_fn(src1_i, src2_i);
      default: alu_res = '0;
    endcase
  end

  assign ready_o = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            if (ctrl_i == ALU_MUL) begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end else begin
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              done_d   = 1'b1;
            end
          end
        end
        ST_MUL: begin
          mul_step = 1'b1;
          if (mul_last) begin
            result_d = mul_product;
            zero_d   = (mul_product == '0);
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  mul_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (flush_i),
    .start_i   (mul_start),
    .step_i    (mul_step),
    .mcand_i   (src1_i),
    .mplier_i  (src2_i),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard fed at issue time.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic             flush_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             done_o;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .flush_i  (flush_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .done_o   (done_o)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [2*WIDTH-1:0] full;
    e.res = '0;
    case (c)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = a + b;
      4'd3: begin full = a * b; e.res = full[WIDTH-1:0]; end
      4'd6: e.res = a - b;
      4'd7: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: e.res = '0;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // Present an operation; the expected result enters the scoreboard in issue order.
  task automatic drive(input logic [3:0] c, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit push);
    valid_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    if (push) sb_q.push_back(model(c, a, b));
  endtask

  always @(posedge clk_i) begin
    #1;
    if (done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {{(WIDTH-1){1'b0}}, done_o}, '0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", result_o, e.res);
        check("sb_zero", {{(WIDTH-1){1'b0}}, zero_o}, {{(WIDTH-1){1'b0}}, e.zero});
      end
    end
  end

  initial begin
    int lows;
    int waited;
    logic [WIDTH-1:0] held;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ctrl_i  = '0;
    src1_i  = '0;
    src2_i  = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    check("rst_result", result_o, '0);
    check("rst_zero",   {31'd0, zero_o},  '0);
    check("rst_done",   {31'd0, done_o},  '0);
    check("rst_ready",  {31'd0, ready_o}, 1);

    // Back-to-back single-cycle ops
    drive(ALU_ADD, 5, 7, 1);               @(negedge clk_i);
    drive(ALU_SUB, 3, 3, 1);               @(negedge clk_i);
    check("b2b_done0", {31'd0, done_o}, 1);
    drive(ALU_SLT, 32'hFFFF_FFFF, 1, 1);   @(negedge clk_i);
    check("b2b_done1", {31'd0, done_o}, 1);
    drive(ALU_OR, 32'hF0, 32'h0F, 1);      @(negedge clk_i);
    check("b2b_done2", {31'd0, done_o}, 1);
    drive(ALU_AND, 32'hFF00, 32'h0FF0, 1); @(negedge clk_i);
    check("b2b_done3", {31'd0, done_o}, 1);
    drive(4'd5, 32'h1234, 32'h1, 1);       @(negedge clk_i);
    check("slt_pos_vs_neg", model(ALU_SLT, 1, 32'hFFFF_FFFF).res, 0);
    valid_i = 1'b0;
    @(negedge clk_i);
    check("idle_no_done", {31'd0, done_o}, 0);

    // MUL 6*7 latency and ready profile
    drive(ALU_MUL, 6, 7, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    lows = 0;
    for (int k = 0; k < 32; k++) begin
      if (!ready_o && !done_o) lows++;
      @(negedge clk_i);
    end
    check("mul_ready_low_cycles", lows, WIDTH);
    check("mul_done_ready", {30'd0, done_o, ready_o}, 2'b11);
    check("mul_42", result_o, 42);

    // Wide multiplies
    drive(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (WIDTH) @(negedge clk_i);
    check("mul_m1_m1", result_o, 1);
    drive(ALU_MUL, 32'h10000, 32'h10000, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (WIDTH) @(negedge clk_i);
    check("mul_overflow_zero", {31'd0, zero_o}, 1);

    // ADD held on valid_i while MUL is in flight
    drive(ALU_MUL, 32'd1000, 32'd3, 1);
    @(negedge clk_i);
    drive(ALU_ADD, 32'd100, 32'd23, 1);
    waited = 0;
    while (!ready_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    check("held_wait_bounded", {31'd0, (waited < 40)}, 1);
    check("held_mul_done_at_ready", {31'd0, done_o}, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("held_add_done_next", {31'd0, done_o}, 1);
    check("held_add_value", result_o, 123);

    // Flush at iteration 10 with a simultaneous valid ADD
    drive(ALU_MUL, 32'd9, 32'd9, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    held = result_o;
    drive(ALU_ADD, 32'd1, 32'd1, 0);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_no_done", {31'd0, done_o}, 0);
    check("flush_result_hold", result_o, held);
    check("flush_ready", {31'd0, ready_o}, 1);
    repeat (WIDTH) @(negedge clk_i);
    check("flush_result_still", result_o, held);

    // Asynchronous reset in the middle of a multiply
    drive(ALU_MUL, 32'd5, 32'd5, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("pre_reset_busy", {31'd0, ready_o}, 0);
    rst_i = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, ready_o}, 1);
    check("async_rst_result", result_o, 0);
    check("async_rst_done", {31'd0, done_o}, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (WIDTH + 2) @(negedge clk_i);
    check("post_reset_no_done", {31'd0, done_o}, 0);

    waited = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge clk_i);
      waited++;
    end
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
